// File: rtl/div_pkg.sv
// Shared definitions for the signed restoring divider: default width, counter width,
// FSM state encoding and the quotient pattern reported on divide-by-zero.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned CNT_W     = $clog2(DIV_WIDTH);

    localparam logic [DIV_WIDTH-1:0] DBZ_QUO = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits and record the quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_WIDTH
) (
    input  logic [W-1:0] i_p,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_p_next,
    output logic [W-1:0] o_a_next
);

    logic [W:0] w_shift;
    logic       w_ge;

    // W+1 bits so the shifted remainder can never wrap before the compare
    assign w_shift  = {i_p, i_a[W-1]};
    assign w_ge     = (w_shift >= {1'b0, i_b});
    assign o_p_next = w_ge ? W'(w_shift - {1'b0, i_b}) : w_shift[W-1:0];
    assign o_a_next = {i_a[W-2:0], w_ge};

endmodule

// File: rtl/divider.sv
// Sequential signed restoring divider, one quotient bit per clock; results held until the next start.
// Optional DIVIDER_EARLY_EXIT_EN skips the iteration when |opB|==0 or |opA|<|opB|.
module divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             res_ok,
    output logic             div_by_zero
);

    localparam int unsigned CW = (CNT_W > $clog2(WIDTH)) ? CNT_W : $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_busy;
    logic             r_res_ok;
    logic             r_dbz;

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_p_next;
    logic             w_accept;
    logic             w_early;
    logic             w_b_zero;

    function automatic logic [WIDTH-1:0] cneg(input logic neg, input logic [WIDTH-1:0] x);
        return neg ? (~x + WIDTH'(1)) : x;
    endfunction

    // Unsigned magnitudes: the most negative value maps onto 2^(WIDTH-1) without overflow
    assign w_mag_a  = cneg(opA[WIDTH-1], opA);
    assign w_mag_b  = cneg(opB[WIDTH-1], opB);
    assign w_b_zero = (r_b == '0);

`ifdef DIVIDER_EARLY_EXIT_EN
    assign w_early = (w_mag_b == '0) || (w_mag_a < w_mag_b);
`else
    assign w_early = 1'b0;
`endif

    div_step #(.W(WIDTH)) u_step (
        .i_p      (r_p),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_p_next (w_p_next),
        .o_a_next (w_a_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // DONE only relaunches once the held result has actually been presented on res_ok
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE:  w_accept = start;
            S_DIV:   if (r_cnt == CW'(WIDTH - 1)) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  w_accept = start && r_res_ok;
            default: w_state_next = S_IDLE;
        endcase
        if (w_accept) begin
            w_state_next = w_early ? S_FIX : S_DIV;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_p      <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_busy   <= 1'b0;
            r_res_ok <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_busy <= (w_state_next == S_DIV) || (w_state_next == S_FIX);
            if (w_accept) begin
                r_a      <= w_early ? '0 : w_mag_a;
                r_p      <= w_early ? w_mag_a : '0;
                r_b      <= w_mag_b;
                r_sign_q <= opA[WIDTH-1] ^ opB[WIDTH-1];
                r_sign_r <= opA[WIDTH-1];
                r_cnt    <= '0;
                r_res_ok <= 1'b0;
                r_dbz    <= 1'b0;
            end else begin
                case (r_state)
                    S_DIV: begin
                        r_a   <= w_a_next;
                        r_p   <= w_p_next;
                        r_cnt <= r_cnt + CW'(1);
                    end
                    // With a zero divisor every step shifts opA straight into P, so rem is opA
                    S_FIX: begin
                        r_quo <= w_b_zero ? {WIDTH{DBZ_QUO[0]}} : cneg(r_sign_q, r_a);
                        r_rem <= cneg(r_sign_r, r_p);
                        r_dbz <= w_b_zero;
                    end
                    S_DONE: r_res_ok <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign quo         = r_quo;
    assign rem         = r_rem;
    assign busy        = r_busy;
    assign res_ok      = r_res_ok;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases plus random operands against an arithmetic reference.
// Latency expectations follow DIVIDER_EARLY_EXIT_EN when it is defined for the build.
module tb_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        busy;
    logic        res_ok;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_q, m_r, m_q2, m_r2, ra, rb;
    logic        m_dz, m_dz2;
    int          m_lat, m_lat2, cnt;

    divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .opA         (opA),
        .opB         (opB),
        .quo         (quo),
        .rem         (rem),
        .busy        (busy),
        .res_ok      (res_ok),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed arithmetic with the documented special cases
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output int lat);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ma = (sa < 0) ? -sa : sa;
        longint mb = (sb < 0) ? -sb : sb;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            dz = 1'b0;
        end
        lat = 34;
`ifdef DIVIDER_EARLY_EXIT_EN
        if (mb == 0 || ma < mb) lat = 2;
`else
        if (ma < 0) lat = 0;
`endif
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input int pulse);
        logic [31:0] eq, er;
        logic        edz;
        int          elat;
        int          n;
        model(a, b, eq, er, edz, elat);
        opA   = a;
        opB   = b;
        start = 1'b1;
        tick;
        start = 1'b0;
        check({tag, ".busy_after_start"}, 32'(busy), 32'd1);
        check({tag, ".res_ok_dropped"}, 32'(res_ok), 32'd0);
        n = 0;
        while (!res_ok && n < 100) begin
            opA   = $urandom;
            opB   = $urandom;
            start = (pulse != 0) && (n + 1 == pulse);
            tick;
            n++;
        end
        start = 1'b0;
        check({tag, ".latency"}, 32'(n), 32'(elat));
        check({tag, ".quo"}, quo, eq);
        check({tag, ".rem"}, rem, er);
        check({tag, ".dbz"}, 32'(div_by_zero), 32'(edz));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        opA   = '0;
        opB   = '0;
        tick;
        tick;
        check("reset.quo", quo, 32'd0);
        check("reset.rem", rem, 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.res_ok", 32'(res_ok), 32'd0);
        check("reset.dbz", 32'(div_by_zero), 32'd0);
        reset = 1'b0;
        tick;
        check("idle.res_ok", 32'(res_ok), 32'd0);

        run_op("t1_100_7", 32'd100, 32'd7, 0);
        run_op("t2_m100_7", -32'sd100, 32'd7, 0);
        run_op("t2_100_m7", 32'd100, -32'sd7, 0);
        run_op("t3_5_0", 32'd5, 32'd0, 0);
        run_op("t3_9_3", 32'd9, 32'd3, 0);
        run_op("t4_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("t4_max_1", 32'h7FFF_FFFF, 32'd1, 0);
        run_op("t4_min_0", 32'h8000_0000, 32'd0, 0);
        run_op("ign_start", 32'd100, 32'd7, 10);

        // Abort mid-operation: an ignored start at clk 10, reset at clk 20
        opA   = 32'd100;
        opB   = 32'd7;
        start = 1'b1;
        tick;
        for (int i = 1; i < 20; i++) begin
            start = (i == 10);
            if (i == 10) begin
                opA = 32'd1;
                opB = 32'd1;
            end
            tick;
        end
        start = 1'b0;
        check("t5.busy_before_reset", 32'(busy), 32'd1);
        check("t5.res_ok_before_reset", 32'(res_ok), 32'd0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("t5.quo", quo, 32'd0);
        check("t5.rem", rem, 32'd0);
        check("t5.busy", 32'(busy), 32'd0);
        check("t5.res_ok", 32'(res_ok), 32'd0);
        check("t5.dbz", 32'(div_by_zero), 32'd0);
        tick;
        check("t5.idle_res_ok", 32'(res_ok), 32'd0);
        run_op("t5_50_5", 32'd50, 32'd5, 0);

        // Back-to-back relaunch with start held high through DONE
        model(32'd1000, -32'sd9, m_q, m_r, m_dz, m_lat);
        model(-32'sd77777, 32'd123, m_q2, m_r2, m_dz2, m_lat2);
        opA   = 32'd1000;
        opB   = -32'sd9;
        start = 1'b1;
        tick;
        opA = -32'sd77777;
        opB = 32'd123;
        cnt = 0;
        while (!res_ok && cnt < 100) begin
            tick;
            cnt++;
        end
        check("t6.low_cycles_1", 32'(cnt), 32'(m_lat));
        check("t6.quo_1", quo, m_q);
        check("t6.rem_1", rem, m_r);
        tick;
        check("t6.relaunch_res_ok", 32'(res_ok), 32'd0);
        check("t6.relaunch_busy", 32'(busy), 32'd1);
        cnt = 0;
        while (!res_ok && cnt < 100) begin
            tick;
            cnt++;
        end
        start = 1'b0;
        check("t6.low_cycles_2", 32'(cnt), 32'(m_lat2));
        check("t6.quo_2", quo, m_q2);
        check("t6.rem_2", rem, m_r2);
        tick;
        tick;
        check("t6.hold_res_ok", 32'(res_ok), 32'd1);
        check("t6.hold_quo", quo, m_q2);

        run_op("ee_3_7", 32'd3, 32'd7, 0);
        run_op("ee_m3_7", -32'sd3, 32'd7, 0);
        run_op("ee_0_m5", 32'd0, -32'sd5, 0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = $urandom;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = -32'($urandom_range(1, 1000));
                3: rb = ra >> $urandom_range(0, 31);
                default: begin
                    ra = 32'h8000_0000;
                    rb = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'd1;
                end
            endcase
            run_op("rnd", ra, rb, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
